// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/single-step controller for a soft CPU.
// Produces a one-cycle clock-enable per executed instruction from a
// programmable tick divider, supports one instruction-address breakpoint
// and counts every issued instruction.
module cpu_run_ctrl #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic [DIV_W-1:0] div_val,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [31:0]      cycle_cnt
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } run_state_e;

    run_state_e       state_q,     state_d;
    logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
    logic             cpu_en_q,    cpu_en_d;
    logic             bp_hit_q,    bp_hit_d;
    logic             bp_skip_q,   bp_skip_d;
    logic [31:0]      cycle_cnt_q, cycle_cnt_d;

    logic             active;
    logic             tick_due;
    logic             bp_match;
    logic             issue;

    // Tick qualification: divider only runs while executing, and the
    // breakpoint compare is masked for the first tick after leaving BREAK.
    always_comb begin
        active   = (state_q == ST_RUN) || (state_q == ST_STEP);
        // >= rather than == so that lowering div_val below the running
        // count fires at once instead of waiting for the counter to wrap.
        tick_due = active && (div_cnt_q >= div_val);
        bp_match = bp_en && (pc == bp_addr) && !bp_skip_q;
    end

    // Next-state logic for the run FSM and the breakpoint-skip flag.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        bp_skip_d = bp_skip_q;
        issue     = 1'b0;

        unique case (state_q)
            ST_HALT: begin
                // halt_req wins over the others but has nothing to do here.
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (halt_req) begin
                    state_d   = ST_HALT;
                    bp_skip_d = 1'b0;
                end else if (tick_due) begin
                    if (bp_match) begin
                        state_d = ST_BREAK;
                    end else begin
                        issue     = 1'b1;
                        bp_skip_d = 1'b0;
                    end
                end
            end

            ST_STEP: begin
                if (halt_req) begin
                    state_d   = ST_HALT;
                    bp_skip_d = 1'b0;
                end else if (tick_due) begin
                    if (bp_match) begin
                        state_d = ST_BREAK;
                    end else begin
                        issue     = 1'b1;
                        state_d   = ST_HALT;
                        bp_skip_d = 1'b0;
                    end
                end
            end

            ST_BREAK: begin
                // Resuming from a breakpoint must not re-trigger on the
                // very instruction that stopped us.
                if (halt_req) begin
                    state_d   = ST_HALT;
                    bp_skip_d = 1'b0;
                end else if (step_req) begin
                    state_d   = ST_STEP;
                    bp_skip_d = 1'b1;
                end else if (run_req) begin
                    state_d   = ST_RUN;
                    bp_skip_d = 1'b1;
                end
            end

            default: begin
                state_d   = ST_HALT;
                bp_skip_d = 1'b0;
            end
        endcase
    end

    // Divider, enable, breakpoint flag and instruction counter next values.
    always_comb begin
        if (tick_due || (state_d != state_q)) begin
            div_cnt_d = '0;
        end else if (active) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end else begin
            div_cnt_d = '0;
        end

        cpu_en_d    = issue;
        bp_hit_d    = (state_d == ST_BREAK);
        // Counts the pulse in the same edge that raises cpu_en; natural
        // 32-bit wrap from all-ones to zero.
        cycle_cnt_d = cycle_cnt_q + {31'd0, issue};
    end

    // All controller state; asynchronous reset drops cpu_en immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= ST_HALT;
            div_cnt_q   <= '0;
            cpu_en_q    <= 1'b0;
            bp_hit_q    <= 1'b0;
            bp_skip_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            cpu_en_q    <= cpu_en_d;
            bp_hit_q    <= bp_hit_d;
            bp_skip_q   <= bp_skip_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign state     = state_q;
    assign bp_hit    = bp_hit_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl: expected outputs are queued when a
// step is driven and popped/compared one time unit after the clock edge.
module tb_cpu_run_ctrl;

    localparam int DIV_W = 24;
    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_BREAK = 2'd3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run_req = 1'b0;
    logic             halt_req = 1'b0;
    logic             step_req = 1'b0;
    logic [DIV_W-1:0] div_val = '0;
    logic             bp_en = 1'b0;
    logic [31:0]      bp_addr = '0;
    logic [31:0]      pc = '0;
    logic             cpu_en;
    logic [1:0]       state;
    logic             bp_hit;
    logic [31:0]      cycle_cnt;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        en;
        logic        bp;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    cpu_run_ctrl #(.DIV_W(DIV_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .run_req  (run_req),
        .halt_req (halt_req),
        .step_req (step_req),
        .div_val  (div_val),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .cpu_en   (cpu_en),
        .state    (state),
        .bp_hit   (bp_hit),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [1:0] st, input logic en,
                            input logic bp, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.st = st; e.en = en; e.bp = bp; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        check({e.tag, ".state"},  {30'd0, state},  {30'd0, e.st});
        check({e.tag, ".cpu_en"}, {31'd0, cpu_en}, {31'd0, e.en});
        check({e.tag, ".bp_hit"}, {31'd0, bp_hit}, {31'd0, e.bp});
        check({e.tag, ".cycle"},  cycle_cnt,       e.cnt);
    endtask

    // One clock step: requests held for exactly one edge, outputs checked after it.
    task automatic drive(input logic r, input logic h, input logic s, input logic [1:0] st,
                         input logic en, input logic bp, input logic [31:0] cnt, input string tag);
        @(negedge clk);
        run_req  = r;
        halt_req = h;
        step_req = s;
        push_exp(tag, st, en, bp, cnt);
        @(posedge clk);
        #1;
        run_req  = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        compare_outputs();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #2;
        push_exp(tag, S_HALT, 1'b0, 1'b0, 32'd0);
        compare_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle: stays in HALT without requests.
        do_reset("reset0");
        drive(0, 0, 0, S_HALT, 0, 0, 0, "idle_halt");
        drive(0, 1, 0, S_HALT, 0, 0, 0, "halt_in_halt");

        // div_val=3 free run: cpu_en on edges 4, 8, 12 after RUN entry.
        div_val = 3;
        drive(1, 0, 0, S_RUN, 0, 0, 0, "div3_enter");
        for (int i = 1; i <= 12; i++)
            drive(0, 0, 0, S_RUN, (i % 4 == 0), 0, 32'(i / 4), $sformatf("div3_c%0d", i));
        drive(0, 1, 0, S_HALT, 0, 0, 3, "div3_halt");

        // Request priority and single step with div_val=0.
        do_reset("reset1");
        div_val = 0;
        drive(0, 1, 1, S_HALT, 0, 0, 0, "halt_beats_step");
        drive(1, 0, 1, S_STEP, 0, 0, 0, "step_beats_run");
        drive(0, 0, 0, S_HALT, 1, 0, 1, "step_tick");
        drive(0, 0, 0, S_HALT, 0, 0, 1, "step_single");

        // div_val=0 run is continuous; halt edge issues no tick.
        drive(1, 0, 0, S_RUN,  0, 0, 1, "run0_enter");
        drive(0, 0, 0, S_RUN,  1, 0, 2, "run0_a");
        drive(1, 0, 1, S_RUN,  1, 0, 3, "run0_ignore_req");
        drive(0, 1, 0, S_HALT, 0, 0, 3, "run0_halt_notick");
        drive(0, 0, 0, S_HALT, 0, 0, 3, "run0_halted");

        // Lowering div_val below the running count ticks at the next edge.
        div_val = 5;
        drive(1, 0, 0, S_RUN, 0, 0, 3, "lower_enter");
        drive(0, 0, 0, S_RUN, 0, 0, 3, "lower_c1");
        drive(0, 0, 0, S_RUN, 0, 0, 3, "lower_c2");
        drive(0, 0, 0, S_RUN, 0, 0, 3, "lower_c3");
        div_val = 1;
        drive(0, 0, 0, S_RUN, 1, 0, 4, "lower_tick");
        drive(0, 1, 0, S_HALT, 0, 0, 4, "lower_halt");

        // Breakpoint at 0x10 with div_val=1.
        do_reset("reset2");
        div_val = 1;
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        pc      = 32'h0C;
        drive(1, 0, 0, S_RUN, 0, 0, 0, "bp_enter");
        drive(0, 0, 0, S_RUN, 0, 0, 0, "bp_c1");
        drive(0, 0, 0, S_RUN, 1, 0, 1, "bp_tick_0c");
        pc = 32'h10;
        drive(0, 0, 0, S_RUN,   0, 0, 1, "bp_c3");
        drive(0, 0, 0, S_BREAK, 0, 1, 1, "bp_hit_10");
        drive(0, 0, 0, S_BREAK, 0, 1, 1, "bp_hold");
        drive(1, 0, 0, S_RUN,   0, 0, 1, "bp_resume");
        drive(0, 0, 0, S_RUN,   0, 0, 1, "bp_res_c1");
        drive(0, 0, 0, S_RUN,   1, 0, 2, "bp_skip_tick");
        drive(0, 0, 0, S_RUN,   0, 0, 2, "bp_res_c3");
        drive(0, 0, 0, S_BREAK, 0, 1, 2, "bp_rehit");
        // Step out of BREAK skips the compare; step from HALT compares.
        drive(0, 0, 1, S_STEP,  0, 0, 2, "bp_step_brk");
        drive(0, 0, 0, S_STEP,  0, 0, 2, "bp_step_c1");
        drive(0, 0, 0, S_HALT,  1, 0, 3, "bp_step_tick");
        drive(0, 0, 1, S_STEP,  0, 0, 3, "bp_step_halt");
        drive(0, 0, 0, S_STEP,  0, 0, 3, "bp_step2_c1");
        drive(0, 0, 0, S_BREAK, 0, 1, 3, "bp_step_hit");
        drive(0, 1, 0, S_HALT,  0, 0, 3, "bp_halt");
        bp_en = 1'b0;

        // Counter wrap from all-ones via a single step.
        do_reset("reset3");
        div_val = 0;
        @(negedge clk);
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        drive(0, 0, 1, S_STEP, 0, 0, 32'hFFFF_FFFF, "wrap_step");
        drive(0, 0, 0, S_HALT, 1, 0, 32'd0,         "wrap_zero");

        // Asynchronous reset in the middle of a RUN burst.
        drive(1, 0, 0, S_RUN, 0, 0, 0, "mid_enter");
        drive(0, 0, 0, S_RUN, 1, 0, 1, "mid_run");
        #2;
        reset = 1'b1;
        #1;
        push_exp("mid_reset_async", S_HALT, 1'b0, 1'b0, 32'd0);
        compare_outputs();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, S_HALT, 0, 0, 0, "post_reset_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
